// File: rtl/npc_mem_pkg.sv
// Shared definitions for the instruction-memory access path: ROM geometry,
// the error fill word, arbiter state encoding, requester ids and the
// address legality check used when a request is granted.
package npc_mem_pkg;

  // Byte address of ROM word 0.
  localparam logic [31:0] IMEM_BASE  = 32'h8000_0000;
  // ROM depth in 32-bit words.
  localparam int unsigned IMEM_DEPTH = 2048;
  // Word returned instead of ROM data when an access is illegal.
  localparam logic [31:0] NOP_INST   = 32'h0000_0013;

  // IDLE: no response outstanding. BUSY: one response held for its owner.
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  // Requester id: 0 = IFU fetch (M0), 1 = LSU/debug read (M1).
  typedef logic req_id_t;
  localparam req_id_t REQ_M0 = 1'b0;
  localparam req_id_t REQ_M1 = 1'b1;

  // An access is illegal when it is not word aligned or its word offset
  // from the ROM base falls outside the ROM. The subtraction wraps, so an
  // address below the base lands on a huge offset and is rejected too.
  function automatic logic addr_err(input logic [31:0] addr,
                                    input logic [31:0] base,
                                    input logic [31:0] depth);
    logic [31:0] off;
    off = addr - base;
    return (addr[1:0] != 2'b00) || ((off >> 2) >= depth);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. A lone requester always wins; on contention
// the requester named by ptr wins. Whenever a grant is issued the pointer
// moves to the requester that did not win, so a loser is served next.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  input  logic       en,
  output logic [1:0] gnt,
  output logic       next_ptr
);

  import npc_mem_pkg::*;

  // Pick the winner and the pointer value to load if the grant is taken.
  always_comb begin
    gnt      = 2'b00;
    next_ptr = ptr;
    if (en) begin
      case (req)
        2'b01: begin
          gnt      = 2'b01;
          next_ptr = REQ_M1;
        end
        2'b10: begin
          gnt      = 2'b10;
          next_ptr = REQ_M0;
        end
        2'b11: begin
          if (ptr == REQ_M0) begin
            gnt      = 2'b01;
            next_ptr = REQ_M1;
          end else begin
            gnt      = 2'b10;
            next_ptr = REQ_M0;
          end
        end
        default: begin
          gnt      = 2'b00;
          next_ptr = ptr;
        end
      endcase
    end else begin
      gnt      = 2'b00;
      next_ptr = ptr;
    end
  end

endmodule

// File: rtl/imem_arbiter.sv
// Shares the combinational-read instruction ROM between the IFU fetch (M0)
// and the LSU/debug read path (M1). One request is granted per cycle; the
// ROM word is captured on the grant edge and presented to the owner on the
// following cycle, held until the owner accepts it. A new grant may be
// issued in the same cycle the current response is consumed, giving one
// access per cycle when nobody stalls.
module imem_arbiter #(
  parameter logic [31:0] BASE_ADDR   = npc_mem_pkg::IMEM_BASE,
  parameter int unsigned DEPTH_WORDS = npc_mem_pkg::IMEM_DEPTH,
  parameter logic [31:0] NOP_INST    = npc_mem_pkg::NOP_INST
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req_valid,
  output logic        m0_req_ready,
  input  logic [31:0] m0_req_addr,
  output logic        m0_rsp_valid,
  input  logic        m0_rsp_ready,
  output logic [31:0] m0_rsp_data,
  output logic        m0_rsp_err,
  input  logic        m1_req_valid,
  output logic        m1_req_ready,
  input  logic [31:0] m1_req_addr,
  output logic        m1_rsp_valid,
  input  logic        m1_rsp_ready,
  output logic [31:0] m1_rsp_data,
  output logic        m1_rsp_err,
  output logic [31:0] mem_pc,
  input  logic [31:0] mem_inst
);

  import npc_mem_pkg::*;

  localparam logic [31:0] DEPTH_W = 32'(DEPTH_WORDS);

  // Arbiter state and response registers.
  arb_state_t  state_r;
  req_id_t     owner_r;
  req_id_t     rr_ptr_r;
  logic        m0_rsp_valid_r;
  logic [31:0] m0_rsp_data_r;
  logic        m0_rsp_err_r;
  logic        m1_rsp_valid_r;
  logic [31:0] m1_rsp_data_r;
  logic        m1_rsp_err_r;

  // Grant-path signals.
  logic        owner_done_s;
  logic        can_accept_s;
  logic [1:0]  gnt_s;
  req_id_t     next_ptr_s;
  logic        grant_s;
  req_id_t     winner_s;
  logic [31:0] win_addr_s;
  logic        win_err_s;
  logic [31:0] cap_data_s;
  logic [31:0] mem_pc_s;

  // The held response is consumed this cycle when its owner is ready.
  always_comb begin
    owner_done_s = 1'b0;
    if (owner_r == REQ_M0) begin
      owner_done_s = m0_rsp_valid_r & m0_rsp_ready;
    end else begin
      owner_done_s = m1_rsp_valid_r & m1_rsp_ready;
    end
  end

  // A grant may be issued when nothing is held or the held response leaves
  // this cycle. Reset keeps the window shut so no ready escapes during it.
  always_comb begin
    can_accept_s = 1'b0;
    if (!rst_n) begin
      can_accept_s = 1'b0;
    end else if (state_r == IDLE) begin
      can_accept_s = 1'b1;
    end else begin
      can_accept_s = owner_done_s;
    end
  end

  rr_arb2 u_rr_arb2 (
    .req      ({m1_req_valid, m0_req_valid}),
    .ptr      (rr_ptr_r),
    .en       (can_accept_s),
    .gnt      (gnt_s),
    .next_ptr (next_ptr_s)
  );

  // Select the winning address, drive the ROM and form the capture value.
  always_comb begin
    grant_s = gnt_s[0] | gnt_s[1];
    if (gnt_s[1]) begin
      winner_s   = REQ_M1;
      win_addr_s = m1_req_addr;
    end else begin
      winner_s   = REQ_M0;
      win_addr_s = m0_req_addr;
    end
    win_err_s = addr_err(win_addr_s, BASE_ADDR, DEPTH_W);
    if (win_err_s) begin
      cap_data_s = NOP_INST;
    end else begin
      cap_data_s = mem_inst;
    end
    // Park the ROM address on the base when nothing is granted so the
    // ROM input does not follow idle requester addresses.
    if (grant_s) begin
      mem_pc_s = win_addr_s;
    end else begin
      mem_pc_s = BASE_ADDR;
    end
  end

  assign m0_req_ready = gnt_s[0];
  assign m1_req_ready = gnt_s[1];
  assign mem_pc       = mem_pc_s;

  assign m0_rsp_valid = m0_rsp_valid_r;
  assign m0_rsp_data  = m0_rsp_data_r;
  assign m0_rsp_err   = m0_rsp_err_r;
  assign m1_rsp_valid = m1_rsp_valid_r;
  assign m1_rsp_data  = m1_rsp_data_r;
  assign m1_rsp_err   = m1_rsp_err_r;

  // Capture the granted read for its owner, retire a consumed response, or
  // hold everything stable while the owner stalls. The non-owner's response
  // registers are kept at zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r        <= IDLE;
      owner_r        <= REQ_M0;
      rr_ptr_r       <= REQ_M0;
      m0_rsp_valid_r <= 1'b0;
      m0_rsp_data_r  <= 32'h0000_0000;
      m0_rsp_err_r   <= 1'b0;
      m1_rsp_valid_r <= 1'b0;
      m1_rsp_data_r  <= 32'h0000_0000;
      m1_rsp_err_r   <= 1'b0;
    end else if (grant_s) begin
      state_r  <= BUSY;
      owner_r  <= winner_s;
      rr_ptr_r <= next_ptr_s;
      if (winner_s == REQ_M0) begin
        m0_rsp_valid_r <= 1'b1;
        m0_rsp_data_r  <= cap_data_s;
        m0_rsp_err_r   <= win_err_s;
        m1_rsp_valid_r <= 1'b0;
        m1_rsp_data_r  <= 32'h0000_0000;
        m1_rsp_err_r   <= 1'b0;
      end else begin
        m0_rsp_valid_r <= 1'b0;
        m0_rsp_data_r  <= 32'h0000_0000;
        m0_rsp_err_r   <= 1'b0;
        m1_rsp_valid_r <= 1'b1;
        m1_rsp_data_r  <= cap_data_s;
        m1_rsp_err_r   <= win_err_s;
      end
    end else if (owner_done_s) begin
      state_r        <= IDLE;
      m0_rsp_valid_r <= 1'b0;
      m0_rsp_data_r  <= 32'h0000_0000;
      m0_rsp_err_r   <= 1'b0;
      m1_rsp_valid_r <= 1'b0;
      m1_rsp_data_r  <= 32'h0000_0000;
      m1_rsp_err_r   <= 1'b0;
    end else begin
      state_r        <= state_r;
      owner_r        <= owner_r;
      rr_ptr_r       <= rr_ptr_r;
      m0_rsp_valid_r <= m0_rsp_valid_r;
      m0_rsp_data_r  <= m0_rsp_data_r;
      m0_rsp_err_r   <= m0_rsp_err_r;
      m1_rsp_valid_r <= m1_rsp_valid_r;
      m1_rsp_data_r  <= m1_rsp_data_r;
      m1_rsp_err_r   <= m1_rsp_err_r;
    end
  end

endmodule
